// File: rtl/apb_timer_multi_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared constants for the multi-channel APB timer: register offsets within a
// channel's 4-byte window, TCR/TSR bit positions and the prescaler width.
// Optional feature macro: TMR_IRQ_EN (adds the interrupt-enable bits of TCR).
// ---------------------------------------------------------------------------
package timer_pkg;

   // Register offsets inside one channel window (PADDR[1:0])
   typedef enum logic [1:0] {
      TDR_OFS  = 2'd0,
      TCR_OFS  = 2'd1,
      TSR_OFS  = 2'd2,
      TCNT_OFS = 2'd3
   } reg_ofs_e;

   // TCR bit positions
   localparam int LOAD_BIT  = 7;
   localparam int DIR_BIT   = 5;
   localparam int EN_BIT    = 4;
   localparam int UDFIE_BIT = 3;
   localparam int OVFIE_BIT = 2;
   localparam int CKS_LSB   = 0;

   // TSR bit positions
   localparam int OVF_BIT = 0;
   localparam int UDF_BIT = 1;

   // Free-running prescaler width
   localparam int PSC_W = 4;

   // Implemented TCR bits; everything else reads back as 0
`ifdef TMR_IRQ_EN
   localparam logic [7:0] TCR_MASK = 8'hBF;
`else
   localparam logic [7:0] TCR_MASK = 8'hB3;
`endif

endpackage

// File: rtl/apb_timer_multi_if.sv
// ---------------------------------------------------------------------------
// apb_timer_multi_if
// APB3 bus bundle for the multi-channel timer.
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA : master -> slave
//   PRDATA/PREADY/PSLVERR            : slave  -> master
// Modports: master (bus driver), slave (timer side).
// ---------------------------------------------------------------------------
interface apb_timer_multi_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_timer_multi_channel.sv
// ---------------------------------------------------------------------------
// timer_channel
// One timer channel: TDR/TCR/TSR/TCNT, the up/down counter and sticky flags.
// Ports:
//   PCLK, PRESET_n         clock, async active-low reset
//   we_tdr/we_tcr/we_tsr   single-cycle write strobes from the APB decoder
//   wdata                  write data
//   tick                   prescaler tick per cks setting (index = cks)
//   rdata                  all four registers, indexed by register offset
//   ovf, udf               registered TSR flags
//   irq_req                (TMR_IRQ_EN only) enabled flag OR, unregistered
// ---------------------------------------------------------------------------
module timer_channel
   import timer_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                       PCLK,
   input  logic                       PRESET_n,
   input  logic                       we_tdr,
   input  logic                       we_tcr,
   input  logic                       we_tsr,
   input  logic [DATA_WIDTH-1:0]      wdata,
   input  logic [PSC_W-1:0]           tick,
   output logic [3:0][DATA_WIDTH-1:0] rdata,
   output logic                       ovf,
   output logic                       udf
`ifdef TMR_IRQ_EN
   ,
   output logic                       irq_req
`endif
);

   logic [DATA_WIDTH-1:0] tdr;
   logic [DATA_WIDTH-1:0] tcr;
   logic [DATA_WIDTH-1:0] tcnt;
   logic [DATA_WIDTH-1:0] tsr_word;
   logic                  ovf_q;
   logic                  udf_q;
   logic                  load;
   logic                  dir;
   logic                  en;
   logic [1:0]            cks;
   logic                  count_up;
   logic                  count_dn;
   logic                  ovf_set;
   logic                  udf_set;

   assign load = tcr[LOAD_BIT];
   assign dir  = tcr[DIR_BIT];
   assign en   = tcr[EN_BIT];
   assign cks  = tcr[CKS_LSB +: 2];

   // Load has priority and suppresses counting and flag setting entirely
   assign count_up = !load && en && tick[cks] && !dir;
   assign count_dn = !load && en && tick[cks] &&  dir;
   assign ovf_set  = count_up && (tcnt == '1);
   assign udf_set  = count_dn && (tcnt == '0);

   // Register file and counter. Flags are sticky and a set in the same cycle
   // as a W1C clear wins, hence the set term ORed outside the clear mask.
   always_ff @(posedge PCLK or negedge PRESET_n) begin
      if (!PRESET_n) begin
         tdr   <= '0;
         tcr   <= '0;
         tcnt  <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (we_tdr)
            tdr <= wdata;
         if (we_tcr)
            tcr <= wdata & DATA_WIDTH'(TCR_MASK);
         ovf_q <= ovf_set | (ovf_q & ~(we_tsr & wdata[OVF_BIT]));
         udf_q <= udf_set | (udf_q & ~(we_tsr & wdata[UDF_BIT]));
         if (load)
            tcnt <= tdr;
         else if (count_up)
            tcnt <= tcnt + 1'b1;
         else if (count_dn)
            tcnt <= tcnt - 1'b1;
      end
   end

   always_comb begin
      tsr_word          = '0;
      tsr_word[OVF_BIT] = ovf_q;
      tsr_word[UDF_BIT] = udf_q;
   end

   assign rdata = {tcnt, tsr_word, tcr, tdr};
   assign ovf   = ovf_q;
   assign udf   = udf_q;

`ifdef TMR_IRQ_EN
   assign irq_req = (ovf_q & tcr[OVFIE_BIT]) | (udf_q & tcr[UDFIE_BIT]);
`endif

endmodule

// File: rtl/apb_timer_multi.sv
// ---------------------------------------------------------------------------
// apb_timer_multi
// NUM_CH independent up/down timers behind one zero-wait-state APB slave,
// sharing a 4-bit free-running prescaler. Each channel occupies 4 bytes:
// TDR, TCR, TSR, TCNT at offsets 0..3; channel index = PADDR[ADDR_WIDTH-1:2].
// Ports:
//   PCLK, PRESET_n    clock, async active-low reset
//   apb               APB slave modport (PSEL..PSLVERR)
//   TMR_OVF, TMR_URF  per-channel sticky overflow / underflow flags
//   TMR_IRQ           registered interrupt, only when TMR_IRQ_EN is defined
// Optional feature macro: TMR_IRQ_EN.
// ---------------------------------------------------------------------------
module apb_timer_multi
   import timer_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CH     = 4
) (
   input  logic              PCLK,
   input  logic              PRESET_n,
   apb_timer_multi_if.slave  apb,
   output logic [NUM_CH-1:0] TMR_OVF,
   output logic [NUM_CH-1:0] TMR_URF
`ifdef TMR_IRQ_EN
   ,
   output logic              TMR_IRQ
`endif
);

   localparam logic [ADDR_WIDTH-2:0] NUM_CH_L = (ADDR_WIDTH-1)'(NUM_CH);

   logic [ADDR_WIDTH-3:0]      ch;
   reg_ofs_e                   ofs;
   logic                       addr_valid;
   logic                       wr_en;
   logic [PSC_W-1:0]           psc;
   logic [PSC_W-1:0]           tick;
   logic [DATA_WIDTH-1:0]      prdata;
   logic [3:0][DATA_WIDTH-1:0] ch_rdata [NUM_CH];

   assign ch         = apb.PADDR[ADDR_WIDTH-1:2];
   assign ofs        = reg_ofs_e'(apb.PADDR[1:0]);
   assign addr_valid = ({1'b0, ch} < NUM_CH_L);
   assign wr_en      = apb.PSEL & apb.PENABLE & apb.PWRITE & addr_valid;

   // Free-running prescaler; no derived clocks, only tick enables
   always_ff @(posedge PCLK or negedge PRESET_n) begin
      if (!PRESET_n)
         psc <= '0;
      else
         psc <= psc + 1'b1;
   end

   // tick[k] pulses once every 2**(k+1) cycles
   for (genvar k = 0; k < PSC_W; k++) begin : g_tick
      assign tick[k] = &psc[k:0];
   end

`ifdef TMR_IRQ_EN
   logic [NUM_CH-1:0] irq_vec;
   logic              irq_q;
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic ch_hit;
      assign ch_hit = wr_en && (ch == (ADDR_WIDTH-2)'(i));

      timer_channel #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_channel (
         .PCLK     (PCLK),
         .PRESET_n (PRESET_n),
         .we_tdr   (ch_hit && (ofs == TDR_OFS)),
         .we_tcr   (ch_hit && (ofs == TCR_OFS)),
         .we_tsr   (ch_hit && (ofs == TSR_OFS)),
         .wdata    (apb.PWDATA),
         .tick     (tick),
         .rdata    (ch_rdata[i]),
         .ovf      (TMR_OVF[i]),
         .udf      (TMR_URF[i])
`ifdef TMR_IRQ_EN
         ,
         .irq_req  (irq_vec[i])
`endif
      );
   end

   // Combinational read mux; an out-of-range channel never matches, so
   // invalid addresses read 0 without a separate check
   always_comb begin
      prdata = '0;
      if (apb.PSEL && !apb.PWRITE) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch == (ADDR_WIDTH-2)'(i))
               prdata = ch_rdata[i][ofs];
         end
      end
   end

   assign apb.PRDATA  = prdata;
   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = apb.PSEL & apb.PENABLE & ~addr_valid;

`ifdef TMR_IRQ_EN
   always_ff @(posedge PCLK or negedge PRESET_n) begin
      if (!PRESET_n)
         irq_q <= 1'b0;
      else
         irq_q <= |irq_vec;
   end

   assign TMR_IRQ = irq_q;
`endif

endmodule

// File: tb/tb_apb_timer_multi.sv
// ---------------------------------------------------------------------------
// tb_apb_timer_multi
// Directed bench for apb_timer_multi (4 channels, 8-bit). Inputs change 1 ns
// after a rising edge; outputs are sampled before the following edge.
// ---------------------------------------------------------------------------
module tb_apb_timer_multi;

   localparam int AW  = 8;
   localparam int DW  = 8;
   localparam int NCH = 4;

`ifdef TMR_IRQ_EN
   localparam logic [7:0] EXP_TCR_ALL = 8'hBF;
`else
   localparam logic [7:0] EXP_TCR_ALL = 8'hB3;
`endif

   logic PCLK = 1'b0;
   logic PRESET_n = 1'b0;
   logic [NCH-1:0] TMR_OVF;
   logic [NCH-1:0] TMR_URF;
`ifdef TMR_IRQ_EN
   logic TMR_IRQ;
`endif

   always #5 PCLK = ~PCLK;

   apb_timer_multi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

   apb_timer_multi #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .NUM_CH     (NCH)
   ) dut (
      .PCLK     (PCLK),
      .PRESET_n (PRESET_n),
      .apb      (apb),
      .TMR_OVF  (TMR_OVF),
      .TMR_URF  (TMR_URF)
`ifdef TMR_IRQ_EN
      ,
      .TMR_IRQ  (TMR_IRQ)
`endif
   );

   int checkCount = 0;
   int failCount  = 0;

   logic [7:0] rd;
   logic [7:0] nv;
   logic       err;
   int         cyc;
   bit         to;

   // Single comparison point: counts and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic apbIdle();
      apb.PSEL    = 1'b0;
      apb.PENABLE = 1'b0;
      apb.PWRITE  = 1'b0;
      apb.PADDR   = '0;
      apb.PWDATA  = '0;
   endtask

   // One APB transfer; data and PSLVERR are captured in the access phase
   task automatic applyStimulus(input logic wr, input logic [7:0] addr,
                                input logic [7:0] wdata,
                                output logic [7:0] rdata, output logic slverr);
      apb.PSEL    = 1'b1;
      apb.PENABLE = 1'b0;
      apb.PWRITE  = wr;
      apb.PADDR   = addr;
      apb.PWDATA  = wdata;
      @(posedge PCLK); #1;
      apb.PENABLE = 1'b1;
      #1;
      rdata  = apb.PRDATA;
      slverr = apb.PSLVERR;
      @(posedge PCLK); #1;
      apbIdle();
   endtask

   task automatic apbWrite(input logic [7:0] addr, input logic [7:0] data,
                           output logic slverr);
      logic [7:0] dummy;
      applyStimulus(1'b1, addr, data, dummy, slverr);
   endtask

   task automatic apbRead(input logic [7:0] addr, output logic [7:0] data,
                          output logic slverr);
      applyStimulus(1'b0, addr, 8'h00, data, slverr);
   endtask

   // Hold a read of addr and wait (bounded) for the value to leave 'old'
   task automatic waitTcntChange(input logic [7:0] addr, input logic [7:0] old,
                                 input int maxCycles, output logic [7:0] newVal,
                                 output int cycles, output bit timedOut);
      apb.PSEL    = 1'b1;
      apb.PENABLE = 1'b0;
      apb.PWRITE  = 1'b0;
      apb.PADDR   = addr;
      cycles   = 0;
      timedOut = 1'b1;
      newVal   = old;
      while (cycles < maxCycles) begin
         @(posedge PCLK); #1;
         cycles++;
         if (apb.PRDATA !== old) begin
            newVal   = apb.PRDATA;
            timedOut = 1'b0;
            break;
         end
      end
      apbIdle();
   endtask

   task automatic holdRead(input logic [7:0] addr, output logic [7:0] data);
      apb.PSEL    = 1'b1;
      apb.PENABLE = 1'b0;
      apb.PWRITE  = 1'b0;
      apb.PADDR   = addr;
      #1;
      data = apb.PRDATA;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      apbIdle();

      // --- Reset state and full register sweep ---
      repeat (3) @(posedge PCLK);
      #1;
      checkOutput("rst_ovf", TMR_OVF, 0);
      checkOutput("rst_urf", TMR_URF, 0);
      checkOutput("rst_prdata", apb.PRDATA, 0);
      checkOutput("rst_pslverr", apb.PSLVERR, 0);
`ifdef TMR_IRQ_EN
      checkOutput("rst_irq", TMR_IRQ, 0);
`endif
      @(negedge PCLK);
      PRESET_n = 1'b1;
      @(posedge PCLK); #1;
      for (int a = 0; a < 4 * NCH; a++) begin
         apbRead(8'(a), rd, err);
         checkOutput($sformatf("sweep_rd_%0h", a), rd, 0);
         checkOutput($sformatf("sweep_err_%0h", a), err, 0);
      end

      // --- Invalid address and read-only TCNT ---
      apbWrite(8'h10, 8'h10, err);
      checkOutput("inv_wr_err", err, 1);
      apbRead(8'h10, rd, err);
      checkOutput("inv_rd_err", err, 1);
      checkOutput("inv_rd_data", rd, 0);
      apbRead(8'h00, rd, err);
      checkOutput("inv_alias_tdr0", rd, 0);
      apbRead(8'h01, rd, err);
      checkOutput("inv_alias_tcr0", rd, 0);
      apbWrite(8'h03, 8'h55, err);
      checkOutput("tcnt_wr_err", err, 0);
      apbRead(8'h03, rd, err);
      checkOutput("tcnt_wr_ignored", rd, 0);

      // --- TCR mask on channel 3 ---
      apbWrite(8'h0D, 8'hFF, err);
      apbRead(8'h0D, rd, err);
      checkOutput("tcr_mask", rd, EXP_TCR_ALL);
      apbWrite(8'h0D, 8'h00, err);

      // --- Channel 1 up count with overflow, cks=0 ---
      apbWrite(8'h04, 8'hFE, err);
      apbWrite(8'h05, 8'h80, err);
      apbWrite(8'h05, 8'h10, err);
      holdRead(8'h07, rd);
      checkOutput("c1_start", rd, 8'hFE);
      waitTcntChange(8'h07, 8'hFE, 4, nv, cyc, to);
      checkOutput("c1_to1", to, 0);
      checkOutput("c1_step1", nv, 8'hFF);
      checkOutput("c1_no_ovf_yet", TMR_OVF, 0);
      waitTcntChange(8'h07, 8'hFF, 4, nv, cyc, to);
      checkOutput("c1_to2", to, 0);
      checkOutput("c1_wrap", nv, 8'h00);
      checkOutput("c1_period", cyc, 2);
      @(posedge PCLK); #1;
      checkOutput("c1_ovf", TMR_OVF, 4'b0010);
      repeat (3) @(posedge PCLK);
      #1;
      checkOutput("c1_ovf_sticky", TMR_OVF, 4'b0010);
      apbRead(8'h06, rd, err);
      checkOutput("c1_tsr", rd, 8'h01);
      apbWrite(8'h06, 8'h01, err);
      checkOutput("c1_w1c", TMR_OVF, 0);
      apbWrite(8'h05, 8'h00, err);

      // --- Channel 2 down count with underflow, cks=3 ---
      apbWrite(8'h08, 8'h01, err);
      apbWrite(8'h09, 8'h80, err);
      apbWrite(8'h09, 8'h33, err);
      holdRead(8'h0B, rd);
      checkOutput("c2_start", rd, 8'h01);
      waitTcntChange(8'h0B, 8'h01, 20, nv, cyc, to);
      checkOutput("c2_to1", to, 0);
      checkOutput("c2_step1", nv, 8'h00);
      waitTcntChange(8'h0B, 8'h00, 20, nv, cyc, to);
      checkOutput("c2_to2", to, 0);
      checkOutput("c2_wrap", nv, 8'hFF);
      checkOutput("c2_period", cyc, 16);
      @(posedge PCLK); #1;
      checkOutput("c2_urf", TMR_URF, 4'b0100);
      checkOutput("c2_no_ovf", TMR_OVF, 0);
      apbRead(8'h03, rd, err);
      checkOutput("c2_ch0_tcnt", rd, 0);
      apbRead(8'h0F, rd, err);
      checkOutput("c2_ch3_tcnt", rd, 0);
      apbRead(8'h04, rd, err);
      checkOutput("c2_ch1_tdr", rd, 8'hFE);
      apbRead(8'h05, rd, err);
      checkOutput("c2_ch1_tcr", rd, 0);
      apbWrite(8'h09, 8'h00, err);

      // --- Flag set coincident with W1C clear on channel 0 ---
      apbWrite(8'h00, 8'hFE, err);
      apbWrite(8'h01, 8'h80, err);
      apbWrite(8'h01, 8'h10, err);
      waitTcntChange(8'h03, 8'hFE, 4, nv, cyc, to);
      checkOutput("c0_to", to, 0);
      checkOutput("c0_ff", nv, 8'hFF);
      // Next tick is two edges away, the same edge this W1C commits on
      apbWrite(8'h02, 8'h01, err);
      @(posedge PCLK); #1;
      checkOutput("c0_set_wins", TMR_OVF, 4'b0001);
      apbRead(8'h02, rd, err);
      checkOutput("c0_tsr", rd, 8'h01);

      // --- Asynchronous reset mid-count ---
      apb.PSEL   = 1'b1;
      apb.PWRITE = 1'b0;
      apb.PADDR  = 8'h03;
      @(posedge PCLK); #2;
      PRESET_n = 1'b0;
      #1;
      checkOutput("arst_tcnt", apb.PRDATA, 0);
      checkOutput("arst_ovf", TMR_OVF, 0);
      checkOutput("arst_urf", TMR_URF, 0);
      apbIdle();
      repeat (2) @(negedge PCLK);
      PRESET_n = 1'b1;
      @(posedge PCLK); #1;
      apbRead(8'h04, rd, err);
      checkOutput("arst_ch1_tdr", rd, 0);
      apbRead(8'h01, rd, err);
      checkOutput("arst_ch0_tcr", rd, 0);

`ifdef TMR_IRQ_EN
      // --- Interrupt from channel 0 overflow ---
      apbWrite(8'h00, 8'hFF, err);
      apbWrite(8'h01, 8'h80, err);
      apbWrite(8'h01, 8'h14, err);
      waitTcntChange(8'h03, 8'hFF, 4, nv, cyc, to);
      checkOutput("irq_to", to, 0);
      checkOutput("irq_wrap", nv, 8'h00);
      checkOutput("irq_not_early", TMR_IRQ, 0);
      @(posedge PCLK); #1;
      @(posedge PCLK); #1;
      checkOutput("irq_set", TMR_IRQ, 1);
      checkOutput("irq_ovf", TMR_OVF[0], 1);
      apbWrite(8'h01, 8'h10, err);
      @(posedge PCLK); #1;
      checkOutput("irq_cleared", TMR_IRQ, 0);
      checkOutput("irq_ovf_kept", TMR_OVF[0], 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
